reg_bank4: RTL and testbench
============================

# reg_bank4

Four-entry register bank that takes its write strobes from the 2-to-4 address decoder. The decoder's four outputs arrive as a one-hot write-select bus. The bank stores WIDTH-bit words and serves two independent registered read ports. It also detects illegal multi-hot write selects and latches them in a sticky error flag.

## Interface
- WIDTH, 32, data width of each entry and of both read ports.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- wr_sel  in  4  one-hot write select from the decoder; bit i is decoder output out_i.
- wr_data  in  WIDTH  write data.
- rd_req  in  1  read request; samples both read addresses.
- rd_addr0  in  2  read port 0 entry index.
- rd_addr1  in  2  read port 1 entry index.
- rd_data0  out  WIDTH  registered read data, port 0.
- rd_data1  out  WIDTH  registered read data, port 1.
- rd_valid  out  1  high for one cycle when rd_data0/1 carry a fresh result.
- err_multi  out  1  sticky flag set by a multi-hot wr_sel.
- err_clr  in  1  synchronous clear of err_multi.

## Operation
- Storage: entries e0..e3, WIDTH bits each. All four entries are writable; there is no hardwired-zero entry.
- Write:
  - When exactly one bit i of wr_sel is set at a clk edge, e_i <= wr_data.
  - wr_sel == 4'b0000 means no write, which is the normal idle state (decoder disabled).
- Illegal select: when popcount(wr_sel) >= 2:
  - No entry is written; all four entries hold their values.
  - err_multi is set at that edge.
- Error flag:
  - err_multi stays high until an edge with err_clr=1 and no new multi-hot select.
  - If err_clr and a multi-hot select coincide, set wins and err_multi stays 1.
- Read:
  - On a clk edge with rd_req=1, rd_data0 <= e[rd_addr0], rd_data1 <= e[rd_addr1], and rd_valid <= 1.
  - On an edge with rd_req=0, rd_valid <= 0 and rd_data0/1 hold their last values.
  - Both ports may address the same entry.
- Write/read collision: the same-edge collision between a write to entry i and a read of entry i is governed by the Configuration section.
- Reset, asserted asynchronously:
  - e0..e3 = 0.
  - rd_data0 = rd_data1 = 0.
  - rd_valid = 0, err_multi = 0.
  - Any write or read in flight is discarded.
  - The first legal write is taken on the first rising edge after reset deasserts.
- No internal state machine beyond the storage, read registers, rd_valid and err_multi. No backpressure: a read request is accepted every cycle.

## Timing
- Write latency: 1 edge. A value written at edge N is readable by a request sampled at edge N+1 and appears on rd_data at N+1's output, i.e. after edge N+1.
- Read latency: 1 cycle. Request sampled at edge N gives rd_data/rd_valid valid after edge N, until edge N+1.
- Back-to-back reads produce rd_valid held high continuously, with new data every cycle.
- err_multi rises after the offending edge; it clears after the err_clr edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- REG_BANK4_BYPASS_EN defined: write-through forwarding. If a legal write to entry i and a read of entry i occur at the same edge, that port's rd_data takes wr_data, the new value.
- REG_BANK4_BYPASS_EN undefined: the read returns the entry's pre-write (old) value. The new value is visible from the next request.
- Multi-hot writes are never forwarded in either build.

## Test plan
- Reset then read:
  - Stimulus: assert reset mid-cycle with e2=32'hDEADBEEF, release, then rd_req=1, rd_addr0=2, rd_addr1=3.
  - Response: rd_data0=rd_data1=0, rd_valid=1 one cycle later, err_multi=0.
- Sweep writes:
  - Stimulus: wr_sel=0001/0010/0100/1000 with data 32'h11/22/33/44, then read pairs (0,1) and (2,3).
  - Response: 32'h11,32'h22 then 32'h33,32'h44.
- Idle select:
  - Stimulus: wr_sel=0000 with wr_data=32'hFFFFFFFF for 4 cycles.
  - Response: all entries unchanged; reads return the prior values.
- Multi-hot:
  - Stimulus: wr_sel=0101, wr_data=32'hAA.
  - Response: e0, e2 unchanged; err_multi=1 and stays 1 until err_clr.
  - Stimulus: err_clr together with wr_sel=0011.
  - Response: err_multi stays 1.
  - Stimulus: err_clr alone.
  - Response: err_multi=0.
- Collision:
  - Stimulus: e1=32'h22, same edge wr_sel=0010 wr_data=32'h99 and rd_req=1 rd_addr0=1.
  - Response: rd_data0=32'h99 with REG_BANK4_BYPASS_EN, 32'h22 without; the next read returns 32'h99 in both builds.
- Read gaps:
  - Stimulus: rd_req pattern 1,1,0,1.
  - Response: rd_valid 1,1,0,1; rd_data holds its value during the 0 cycle.

Source files
------------

// File: rtl/reg_bank4_if.sv
// reg_bank4_if: write/read/error bus for reg_bank4
// Signals: wr_sel, wr_data, rd_req, rd_addr0/1 and err_clr run master -> slave;
// rd_data0/1, rd_valid and err_multi run slave -> master.
interface reg_bank4_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic             rd_req;
    logic [1:0]       rd_addr0;
    logic [1:0]       rd_addr1;
    logic [WIDTH-1:0] rd_data0;
    logic [WIDTH-1:0] rd_data1;
    logic             rd_valid;
    logic             err_multi;
    logic             err_clr;
    modport master (
        output wr_sel, wr_data, rd_req, rd_addr0, rd_addr1, err_clr,
        input  rd_data0, rd_data1, rd_valid, err_multi
    );
    modport slave (
        input  wr_sel, wr_data, rd_req, rd_addr0, rd_addr1, err_clr,
        output rd_data0, rd_data1, rd_valid, err_multi
    );
endinterface

// File: rtl/reg_bank4.sv
// reg_bank4: four-entry register bank with one-hot write select, two registered read ports and a sticky multi-hot error flag
// Ports: clk; reset (async, active-high); bus (reg_bank4_if.slave).
// Option: REG_BANK4_BYPASS_EN forwards same-edge legal write data to a read of the written entry.
module reg_bank4 #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        reset,
    reg_bank4_if.slave bus
);
    logic [WIDTH-1:0] e [4];
    logic             multi;
    logic             one_hot;
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q1;
    always_comb begin
        // x & (x-1) is nonzero exactly when two or more bits are set
        multi = |(bus.wr_sel & (bus.wr_sel - 4'd1));
        one_hot = |bus.wr_sel && !multi;
`ifdef REG_BANK4_BYPASS_EN
        q0 = one_hot && bus.wr_sel[bus.rd_addr0] ? bus.wr_data : e[bus.rd_addr0];
        q1 = one_hot && bus.wr_sel[bus.rd_addr1] ? bus.wr_data : e[bus.rd_addr1];
`else
        q0 = e[bus.rd_addr0];
        q1 = e[bus.rd_addr1];
`endif
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) e[i] <= '0;
            bus.rd_data0 <= '0;
            bus.rd_data1 <= '0;
            bus.rd_valid <= 1'b0;
            bus.err_multi <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) if (one_hot && bus.wr_sel[i]) e[i] <= bus.wr_data;
            if (bus.rd_req) begin
                bus.rd_data0 <= q0;
                bus.rd_data1 <= q1;
            end
            bus.rd_valid <= bus.rd_req;
            // a new multi-hot select wins over a simultaneous clear
            bus.err_multi <= multi || (bus.err_multi && !bus.err_clr);
        end
    end
endmodule

// File: tb/tb_reg_bank4.sv
// tb_reg_bank4: table-driven and randomized self-checking bench for reg_bank4
module tb_reg_bank4;
`ifdef REG_BANK4_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [31:0] COL = BYP ? 32'h99 : 32'h22;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    reg_bank4_if #(.WIDTH(32)) bus();
    reg_bank4 #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    logic [31:0] m [4];
    logic [31:0] md0, md1;
    logic mv, me;
    typedef struct {
        logic [3:0]  sel;
        logic [31:0] data;
        logic        req;
        logic [1:0]  a0;
        logic [1:0]  a1;
        logic        clr;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        v;
        logic        e;
    } vec_t;
    vec_t vt [22];
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, x);
        end
    endtask
    task automatic model_reset();
        for (int i = 0; i < 4; i++) m[i] = '0;
        md0 = '0;
        md1 = '0;
        mv = 1'b0;
        me = 1'b0;
    endtask
    task automatic step(input logic [3:0] s, input logic [31:0] d, input logic r,
                        input logic [1:0] x0, input logic [1:0] x1, input logic c);
        int pop;
        @(negedge clk);
        bus.wr_sel = s;
        bus.wr_data = d;
        bus.rd_req = r;
        bus.rd_addr0 = x0;
        bus.rd_addr1 = x1;
        bus.err_clr = c;
        pop = $countones(s);
        if (r) begin
            md0 = (BYP && pop == 1 && s[x0]) ? d : m[x0];
            md1 = (BYP && pop == 1 && s[x1]) ? d : m[x1];
        end
        mv = r;
        if (pop == 1) for (int i = 0; i < 4; i++) if (s[i]) m[i] = d;
        me = (pop >= 2) ? 1'b1 : (c ? 1'b0 : me);
        @(posedge clk);
        #1;
    endtask
    task automatic chk_model(input string tag);
        chk({tag, " rd_data0"}, bus.rd_data0, md0);
        chk({tag, " rd_data1"}, bus.rd_data1, md1);
        chk({tag, " rd_valid"}, 32'(bus.rd_valid), 32'(mv));
        chk({tag, " err_multi"}, 32'(bus.err_multi), 32'(me));
    endtask
    initial begin
        vt[0]  = '{4'b0000, 32'h0,        1'b1, 2'd2, 2'd3, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0};
        vt[1]  = '{4'b0001, 32'h11,       1'b0, 2'd0, 2'd0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0};
        vt[2]  = '{4'b0010, 32'h22,       1'b0, 2'd0, 2'd0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0};
        vt[3]  = '{4'b0100, 32'h33,       1'b0, 2'd0, 2'd0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0};
        vt[4]  = '{4'b1000, 32'h44,       1'b0, 2'd0, 2'd0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0};
        vt[5]  = '{4'b0000, 32'h0,        1'b1, 2'd0, 2'd1, 1'b0, 32'h11, 32'h22, 1'b1, 1'b0};
        vt[6]  = '{4'b0000, 32'h0,        1'b1, 2'd2, 2'd3, 1'b0, 32'h33, 32'h44, 1'b1, 1'b0};
        vt[7]  = '{4'b0000, 32'hFFFFFFFF, 1'b0, 2'd0, 2'd0, 1'b0, 32'h33, 32'h44, 1'b0, 1'b0};
        vt[8]  = '{4'b0000, 32'hFFFFFFFF, 1'b0, 2'd0, 2'd0, 1'b0, 32'h33, 32'h44, 1'b0, 1'b0};
        vt[9]  = '{4'b0000, 32'hFFFFFFFF, 1'b0, 2'd0, 2'd0, 1'b0, 32'h33, 32'h44, 1'b0, 1'b0};
        vt[10] = '{4'b0000, 32'hFFFFFFFF, 1'b0, 2'd0, 2'd0, 1'b0, 32'h33, 32'h44, 1'b0, 1'b0};
        vt[11] = '{4'b0000, 32'hFFFFFFFF, 1'b1, 2'd0, 2'd1, 1'b0, 32'h11, 32'h22, 1'b1, 1'b0};
        vt[12] = '{4'b0101, 32'hAA,       1'b0, 2'd0, 2'd0, 1'b0, 32'h11, 32'h22, 1'b0, 1'b1};
        vt[13] = '{4'b0000, 32'h0,        1'b1, 2'd0, 2'd2, 1'b0, 32'h11, 32'h33, 1'b1, 1'b1};
        vt[14] = '{4'b0011, 32'hAA,       1'b0, 2'd0, 2'd0, 1'b1, 32'h11, 32'h33, 1'b0, 1'b1};
        vt[15] = '{4'b0000, 32'h0,        1'b0, 2'd0, 2'd0, 1'b1, 32'h11, 32'h33, 1'b0, 1'b0};
        vt[16] = '{4'b0010, 32'h99,       1'b1, 2'd1, 2'd1, 1'b0, COL,    COL,    1'b1, 1'b0};
        vt[17] = '{4'b0000, 32'h0,        1'b1, 2'd1, 2'd0, 1'b0, 32'h99, 32'h11, 1'b1, 1'b0};
        vt[18] = '{4'b0000, 32'h0,        1'b1, 2'd2, 2'd3, 1'b0, 32'h33, 32'h44, 1'b1, 1'b0};
        vt[19] = '{4'b0000, 32'h0,        1'b1, 2'd3, 2'd2, 1'b0, 32'h44, 32'h33, 1'b1, 1'b0};
        vt[20] = '{4'b0000, 32'h0,        1'b0, 2'd0, 2'd0, 1'b0, 32'h44, 32'h33, 1'b0, 1'b0};
        vt[21] = '{4'b0000, 32'h0,        1'b1, 2'd0, 2'd0, 1'b0, 32'h11, 32'h11, 1'b1, 1'b0};
        bus.wr_sel = '0;
        bus.wr_data = '0;
        bus.rd_req = 1'b0;
        bus.rd_addr0 = '0;
        bus.rd_addr1 = '0;
        bus.err_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step(4'b0100, 32'hDEADBEEF, 1'b0, 2'd0, 2'd0, 1'b0);
        step(4'b0000, 32'h0, 1'b1, 2'd2, 2'd0, 1'b0);
        chk("pre-reset rd_data0", bus.rd_data0, 32'hDEADBEEF);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async reset rd_data0", bus.rd_data0, 32'h0);
        chk("async reset rd_data1", bus.rd_data1, 32'h0);
        chk("async reset rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("async reset err_multi", 32'(bus.err_multi), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 22; i++) begin
            step(vt[i].sel, vt[i].data, vt[i].req, vt[i].a0, vt[i].a1, vt[i].clr);
            chk($sformatf("vec%0d rd_data0", i), bus.rd_data0, vt[i].d0);
            chk($sformatf("vec%0d rd_data1", i), bus.rd_data1, vt[i].d1);
            chk($sformatf("vec%0d rd_valid", i), 32'(bus.rd_valid), 32'(vt[i].v));
            chk($sformatf("vec%0d err_multi", i), 32'(bus.err_multi), 32'(vt[i].e));
        end
        for (int i = 0; i < 400; i++) begin
            logic [3:0] s;
            int k;
            k = $urandom_range(0, 9);
            s = k < 3 ? 4'b0000 : k < 8 ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            step(s, $urandom, 1'($urandom), 2'($urandom), 2'($urandom), $urandom_range(0, 5) == 0);
            chk_model($sformatf("rand%0d", i));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
